// File: rtl/fifo_write_arbiter_pkg.sv
// Shared definitions for the FIFO write arbiter and the read-side arbiters built on the same
// round-robin picker.
package fifo_write_arbiter_pkg;

  localparam int unsigned DefaultDataWidth = 32;
  localparam int unsigned DefaultMaxBurst  = 4;
  localparam int unsigned NumReq           = 4;
  localparam int unsigned ReqIdxWidth      = 2;
  localparam int unsigned CountWidth       = 3;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StBurst = 1'b1
  } arb_state_e;

  function automatic logic [NumReq-1:0] idx_to_onehot(input logic [ReqIdxWidth-1:0] idx);
    return NumReq'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_priority_picker_4.sv
// Four-way rotating priority picker: returns the first set request scanning upward from ptr_i.
module rr_priority_picker_4
  import fifo_write_arbiter_pkg::*;
(
  input  logic [NumReq-1:0]      req_i,
  input  logic [ReqIdxWidth-1:0] ptr_i,
  output logic [NumReq-1:0]      grant_o,
  output logic                   found_o,
  output logic [ReqIdxWidth-1:0] idx_o
);

  logic [ReqIdxWidth-1:0] cand;

  // Scan offsets from farthest to nearest so the nearest hit is the one left standing.
  always_comb begin
    found_o = 1'b0;
    idx_o   = ptr_i;
    cand    = ptr_i;
    for (int off = NumReq - 1; off >= 0; off--) begin
      cand = ptr_i + off[ReqIdxWidth-1:0];
      if (req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

  always_comb begin
    grant_o = '0;
    if (found_o) begin
      grant_o = idx_to_onehot(idx_o);
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among four valid/ack requesters, with bounded
// bursts so one requester cannot hold the port indefinitely.
module fifo_write_arbiter
  import fifo_write_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefaultDataWidth,
  parameter int unsigned MAX_BURST  = DefaultMaxBurst,
  parameter int unsigned NUM_REQ    = NumReq
) (
  input  logic                          Clk_In,
  input  logic                          Reset_In,
  input  logic [NUM_REQ-1:0]            Req_In,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] Data_In,
  output logic [NUM_REQ-1:0]            Ack_Out,
  output logic [NUM_REQ-1:0]            Grant_Out,
  output logic                          Fifo_Write_Enable_Out,
  output logic [DATA_WIDTH-1:0]         Fifo_Data_Out,
  input  logic                          Fifo_Full_In,
  output logic [CountWidth-1:0]         Burst_Count_Out
);

  localparam logic [CountWidth-1:0] MaxCount = CountWidth'(MAX_BURST);

  arb_state_e             state_q;
  logic [ReqIdxWidth-1:0] ptr_q;
  logic [ReqIdxWidth-1:0] owner_q;
  logic [NUM_REQ-1:0]     grant_q;
  logic                   we_q;
  logic [DATA_WIDTH-1:0]  data_q;
  logic [CountWidth-1:0]  cnt_q;

  logic [NUM_REQ-1:0]     pick_grant;
  logic                   pick_found;
  logic [ReqIdxWidth-1:0] pick_idx;

  logic                   owner_cont;
  logic                   ack_valid;
  logic [ReqIdxWidth-1:0] win_idx;
  logic [DATA_WIDTH-1:0]  win_data;

  rr_priority_picker_4 u_picker (
    .req_i   (Req_In),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // The owner keeps the port without re-arbitration until it drops Req or hits the burst limit.
  always_comb begin
    owner_cont = (state_q == StBurst) && Req_In[owner_q] && (cnt_q < MaxCount);
    ack_valid  = !Fifo_Full_In && (owner_cont || pick_found);
    win_idx    = owner_cont ? owner_q : pick_idx;
    Ack_Out    = '0;
    if (!Fifo_Full_In) begin
      Ack_Out = owner_cont ? idx_to_onehot(owner_q) : pick_grant;
    end
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == ReqIdxWidth'(i)) begin
        win_data = Data_In[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      owner_q <= '0;
      grant_q <= '0;
      we_q    <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else if (ack_valid) begin
      state_q <= StBurst;
      data_q  <= win_data;
      we_q    <= 1'b1;
      grant_q <= idx_to_onehot(win_idx);
      cnt_q   <= owner_cont ? cnt_q + CountWidth'(1) : CountWidth'(1);
      owner_q <= win_idx;
      ptr_q   <= win_idx + ReqIdxWidth'(1);
    end else if (Fifo_Full_In && (state_q == StBurst)) begin
      // Stall: the burst keeps its owner and count so it can resume once space frees up.
      we_q <= 1'b0;
    end else if (Req_In == '0) begin
      state_q <= StIdle;
      grant_q <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      we_q <= 1'b0;
    end
  end

  assign Grant_Out             = grant_q;
  assign Fifo_Write_Enable_Out = we_q;
  assign Fifo_Data_Out         = data_q;
  assign Burst_Count_Out       = cnt_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: two instances (burst limit 4 and 1), each with its own requesters,
// 8-deep FIFO occupancy model and behavioural arbitration reference.
module tb_fifo_write_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   req   [2];
  logic [127:0] data  [2];
  logic         full  [2];
  logic [3:0]   ack   [2];
  logic [3:0]   grant [2];
  logic         we    [2];
  logic [31:0]  fdata [2];
  logic [2:0]   cnt   [2];

  fifo_write_arbiter #(.DATA_WIDTH(32), .MAX_BURST(4), .NUM_REQ(4)) dut0 (
    .Clk_In(clk), .Reset_In(rst), .Req_In(req[0]), .Data_In(data[0]), .Ack_Out(ack[0]),
    .Grant_Out(grant[0]), .Fifo_Write_Enable_Out(we[0]), .Fifo_Data_Out(fdata[0]),
    .Fifo_Full_In(full[0]), .Burst_Count_Out(cnt[0])
  );

  fifo_write_arbiter #(.DATA_WIDTH(32), .MAX_BURST(1), .NUM_REQ(4)) dut1 (
    .Clk_In(clk), .Reset_In(rst), .Req_In(req[1]), .Data_In(data[1]), .Ack_Out(ack[1]),
    .Grant_Out(grant[1]), .Fifo_Write_Enable_Out(we[1]), .Fifo_Data_Out(fdata[1]),
    .Fifo_Full_In(full[1]), .Burst_Count_Out(cnt[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vec = 0;
  int          err = 0;
  int          maxb [2] = '{4, 1};
  bit          m_busy [2];
  int          m_owner [2];
  int          m_cnt [2];
  int          m_ptr [2];
  logic [3:0]  m_grant [2];
  logic        m_we [2];
  logic [31:0] m_data [2];
  int          pk [2];
  bit          pc [2];
  bit   [3:0]  want [2];
  logic [31:0] word [2][4];
  int          occ [2];
  int          wcount [2];

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] expv);
    vec++;
    assert (obs === expv)
    else begin
      err++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, d, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 0; m_owner[d] = 0; m_cnt[d] = 0; m_ptr[d] = 0;
      m_grant[d] = '0; m_we[d] = 1'b0; m_data[d] = '0;
    end
  endtask

  // Winner per the arbitration rules: no ack when full, owner continues under the limit,
  // otherwise first request found scanning from the rotating pointer.
  task automatic model_pick(input int d);
    pk[d] = -1;
    pc[d] = 0;
    if (!full[d]) begin
      if (m_busy[d] && req[d][m_owner[d]] && m_cnt[d] < maxb[d]) begin
        pk[d] = m_owner[d];
        pc[d] = 1;
      end else begin
        for (int off = 0; off < 4; off++)
          if (pk[d] < 0 && req[d][(m_ptr[d] + off) % 4]) pk[d] = (m_ptr[d] + off) % 4;
      end
    end
  endtask

  task automatic model_clock(input int d);
    int k;
    if (pk[d] >= 0) begin
      k = pk[d];
      m_data[d]  = word[d][k];
      word[d][k] = word[d][k] + 1;
      m_we[d]    = 1'b1;
      m_grant[d] = 4'b0001 << k;
      m_cnt[d]   = pc[d] ? m_cnt[d] + 1 : 1;
      m_owner[d] = k;
      m_busy[d]  = 1;
      m_ptr[d]   = (k + 1) % 4;
    end else if (full[d] && m_busy[d]) begin
      m_we[d] = 1'b0;
    end else if (req[d] == 4'b0000) begin
      m_busy[d] = 0; m_grant[d] = '0; m_we[d] = 1'b0; m_cnt[d] = 0;
    end else begin
      m_we[d] = 1'b0;
    end
  endtask

  // One clock: drive at negedge, check Ack, step the model at posedge, check registers at negedge.
  task automatic cycle(input bit rd, input bit rnd);
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) begin
        if (rnd) begin
          if (want[d][i] && $urandom_range(15) == 0) want[d][i] = 1'b0;
          else if (!want[d][i] && $urandom_range(2) == 0) want[d][i] = 1'b1;
        end
        req[d][i] = want[d][i];
        data[d][32*i +: 32] = word[d][i];
      end
      full[d] = (occ[d] >= 8);
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      model_pick(d);
      chk("ack", d, {28'b0, ack[d]}, (pk[d] < 0) ? 32'd0 : (32'd1 << pk[d]));
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_clock(d);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("grant", d, {28'b0, grant[d]}, {28'b0, m_grant[d]});
      chk("we", d, {31'b0, we[d]}, {31'b0, m_we[d]});
      chk("data", d, fdata[d], m_data[d]);
      chk("count", d, {29'b0, cnt[d]}, 32'(m_cnt[d]));
      if (we[d] === 1'b1) wcount[d]++;
      if (m_we[d]) occ[d]++;
      if (rd && occ[d] > 0) occ[d]--;
    end
  endtask

  // Called just after a negedge; reset spans the following posedge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_grant", d, {28'b0, grant[d]}, 32'd0);
      chk("rst_we", d, {31'b0, we[d]}, 32'd0);
      chk("rst_data", d, fdata[d], 32'd0);
      chk("rst_count", d, {29'b0, cnt[d]}, 32'd0);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req[d] = '0; data[d] = '0; full[d] = 1'b0; want[d] = '0; occ[d] = 0; wcount[d] = 0;
      for (int i = 0; i < 4; i++) word[d][i] = 32'((i + 1) << 24);
    end
    model_reset();
    @(negedge clk);
    do_reset();

    // Reset mid-burst: two words, then reset; requester 0 wins first afterwards.
    want[0] = 4'b0001; want[1] = 4'b0001;
    cycle(1, 0);
    cycle(1, 0);
    do_reset();
    want[0] = 4'b1111; want[1] = 4'b1111;
    cycle(1, 0);
    chk("post_rst_grant", 0, {28'b0, grant[0]}, 32'h1);
    chk("post_rst_grant", 1, {28'b0, grant[1]}, 32'h1);
    want[0] = 4'b0000; want[1] = 4'b0000;
    cycle(1, 0);
    cycle(1, 0);

    // Single requester on lane 2: full-rate writes, burst count wraps back to 1.
    do_reset();
    word[0][2] = 32'h10; word[1][2] = 32'h10;
    want[0] = 4'b0100; want[1] = 4'b0100;
    for (int j = 1; j <= 6; j++) begin
      cycle(1, 0);
      chk("single_data", 0, fdata[0], 32'h10 + 32'(j - 1));
      chk("single_count", 0, {29'b0, cnt[0]}, (j <= 4) ? 32'(j) : 32'(j - 4));
      chk("single_we", 1, {31'b0, we[1]}, 32'd1);
    end

    // Fairness with all four requesting; limit-1 instance rotates every word.
    do_reset();
    want[0] = 4'b1111; want[1] = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      cycle(1, 0);
      chk("rr_grant", 1, {28'b0, grant[1]}, 32'd1 << (j % 4));
    end

    // Burst-limit rotation between lanes 0 and 1 with no gap.
    do_reset();
    want[0] = 4'b0011; want[1] = 4'b0011;
    for (int j = 0; j < 9; j++) begin
      cycle(1, 0);
      chk("rot_grant", 0, {28'b0, grant[0]}, (j < 4 || j >= 8) ? 32'h1 : 32'h2);
    end

    // Backpressure: 8-deep FIFO, no reads, then a single read lets exactly one more word in.
    do_reset();
    for (int d = 0; d < 2; d++) begin occ[d] = 0; wcount[d] = 0; want[d] = 4'b0001; end
    for (int j = 0; j < 12; j++) cycle(0, 0);
    for (int d = 0; d < 2; d++) begin
      chk("full_writes", d, 32'(wcount[d]), 32'd8);
      wcount[d] = 0;
    end
    cycle(1, 0);
    for (int j = 0; j < 4; j++) cycle(0, 0);
    for (int d = 0; d < 2; d++) chk("one_more_write", d, 32'(wcount[d]), 32'd1);

    // Owner 3 drops after two words while requester 1 is waiting.
    do_reset();
    for (int d = 0; d < 2; d++) begin occ[d] = 0; want[d] = 4'b1000; end
    cycle(1, 0);
    want[0] = 4'b1010; want[1] = 4'b1010;
    cycle(1, 0);
    want[0] = 4'b0010; want[1] = 4'b0010;
    cycle(1, 0);
    chk("drop_grant", 0, {28'b0, grant[0]}, 32'h2);
    chk("drop_count", 0, {29'b0, cnt[0]}, 32'd1);

    // Random requests, drops and FIFO reads.
    for (int j = 0; j < 2000; j++) cycle(1'($urandom_range(1)), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Round-robin write arbiter sharing one 32-bit FIFO write port among 4 requesters.
- Each requester uses a valid/ack handshake; the arbiter registers the winning word and drives the FIFO write port.
- Bounded bursts limit how long one requester can hold the port.
- The arbiter runs on posedge Clk_In, so its registered write outputs are stable when the FIFO samples them on negedge.

Parameters:
- DATA_WIDTH, 32, word width of every requester data lane and of the FIFO data.
- MAX_BURST, 4, maximum consecutive words one requester may write before forced rotation. Legal range 1..7.
- NUM_REQ, 4, requester count. Fixed at 4; the pointer and index logic are 2 bits.

Ports:
- Clk_In  input  1  clock. All arbiter state updates on posedge.
- Reset_In  input  1  reset, asynchronous, active-high.
- Req_In  input  4  per-requester valid. Bit i high means Data_In lane i holds a word.
- Data_In  input  128  packed requester data. Lane i is bits [32*i+31 : 32*i].
- Ack_Out  output  4  combinational, one-hot or zero. Bit i high means lane i's word is captured at the coming posedge.
- Grant_Out  output  4  registered one-hot owner of the FIFO port; zero when idle.
- Fifo_Write_Enable_Out  output  1  registered FIFO write strobe.
- Fifo_Data_Out  output  32  registered FIFO write data.
- Fifo_Full_In  input  1  FIFO full flag, sampled at posedge.
- Burst_Count_Out  output  3  registered count of words written by the current owner in the current burst.

Behaviour:
- Reset (asynchronous, any time, including mid-burst):
  - Grant_Out=0, Fifo_Write_Enable_Out=0, Fifo_Data_Out=0, Burst_Count_Out=0.
  - Round-robin pointer=0 (requester 0 has highest priority after reset). State=IDLE.
  - A word whose Ack was high in the reset cycle is discarded, not written.
- States: IDLE, BURST.
- Arbitration (combinational, evaluated every cycle):
  - If Fifo_Full_In=1: no Ack.
  - In BURST, while Req_In[owner]=1 and Burst_Count_Out<MAX_BURST: owner continues; Ack_Out[owner]=1.
  - Otherwise pick the first set Req_In bit scanning from pointer, pointer+1, ... modulo 4.
  - In BURST the pointer equals owner+1, so the current owner is re-picked only if no other requester is asserting.
- Posedge with an Ack to requester k:
  - Fifo_Data_Out<=lane k, Fifo_Write_Enable_Out<=1, Grant_Out<=one-hot(k), state<=BURST.
  - Burst_Count_Out<=Burst_Count_Out+1 if k is the continuing owner, else 1.
  - Pointer<=(k+1) mod 4.
- Posedge with no Ack and Fifo_Full_In=1 while in BURST:
  - Fifo_Write_Enable_Out<=0; Grant_Out, Burst_Count_Out and pointer hold.
  - The burst resumes when full clears, if the owner still requests and the limit is not reached.
- Posedge with no Ack and no request: state<=IDLE, Grant_Out<=0, Fifo_Write_Enable_Out<=0, Burst_Count_Out<=0. Pointer holds.
- Latency: word acked at posedge N is presented to the FIFO during cycle N and written at the negedge inside cycle N.
- Full flag timing: Fifo_Full_In reflects that write before posedge N+1, so the FIFO never overflows.
- Handover: zero bubble. The last word of A's burst and the first word of B's are on consecutive cycles.
- Requester rule: Data/Req must be stable from before posedge until Ack is seen. A requester may drop Req without an Ack; nothing is written.
- Simultaneous full and burst limit: no write; state stays BURST with the counter at MAX_BURST. The next Ack after full clears goes to a new arbitration winner.
- Fifo_Data_Out holds its last value when the write enable is low.

Decomposition:
- Shared package: DATA_WIDTH default, NUM_REQ, state encoding constants (IDLE=0, BURST=1), MAX_BURST default.
- One natural sub-module: rr_priority_picker_4. Inputs: 4-bit request, 2-bit pointer. Outputs: one-hot grant, found flag, 2-bit index. It is reused by later read-side arbiters.

Test Plan:
- Reset mid-burst: Req_In=4'b0001, assert Reset_In for half a cycle after 2 words -> all outputs 0 immediately, nothing further written, next grant goes to requester 0.
- Single requester burst: Req_In=4'b0100 continuously, lane 2 incrementing from 32'h10 -> 32'h10..32'h13 written on 4 consecutive cycles, Burst_Count_Out 1..4, then no bubble because no competitors: the fifth word starts a new burst with count 1.
- Round-robin fairness: Req_In=4'b1111, MAX_BURST=1 -> Grant_Out sequence 0001,0010,0100,1000,0001, one write per cycle.
- Burst limit rotation: Req_In=4'b0011, MAX_BURST=4 -> 4 words from lane 0, then 4 from lane 1 on the next cycle with no gap, then back to lane 0.
- Full backpressure: 8-deep FIFO, Req_In=4'b0001 -> exactly 8 writes, Ack_Out=0 while full. One FIFO read frees a slot -> exactly one more write, no overwrite of unread data.
- Requester drop: owner 3 drops Req after 2 words while Req_In[1]=1 -> next cycle Grant_Out=4'b0010, Burst_Count_Out=1.
